// File: rtl/pool2d_sched_pkg.sv
// Shared state encoding and default geometry for the 2x2 pooling scheduler.
package pool2d_sched_pkg;

    localparam int DefColNum     = 28;
    localparam int DefRowNum     = 28;
    localparam int DefWordlength = 16;

    typedef enum logic [2:0] {
        StFill    = 3'd0,
        StOddAcc  = 3'd1,
        StIssue0  = 3'd2,
        StIssue1  = 3'd3,
        StCapture = 3'd4
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single synchronous write port, two asynchronous read ports.
module pool_line_buf #(
    parameter int unsigned Depth = 28,
    parameter int unsigned Width = 16,
    parameter int unsigned AddrW = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [Width-1:0] i_wdata,
    input  logic [AddrW-1:0] i_raddr0,
    output logic [Width-1:0] o_rdata0,
    input  logic [AddrW-1:0] i_raddr1,
    output logic [Width-1:0] o_rdata1
);

    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/pool2d_sched.sv
// Streams a raster feature map into an external 2x2 max-pool unit: buffers even rows,
// pairs them with odd-row pixels, and registers each pooled result for a ready/valid sink.
module pool2d_sched
    import pool2d_sched_pkg::*;
#(
    parameter int dataColNum = DefColNum,
    parameter int dataRowNum = DefRowNum,
    parameter int wordlength = DefWordlength
) (
    input  logic                         clk,
    input  logic                         irst,
    input  logic                         in_valid,
    input  logic signed [wordlength-1:0] in_pixel,
    output logic                         in_ready,
    output logic                         pool_valid,
    output logic signed [wordlength-1:0] pool_px0,
    output logic signed [wordlength-1:0] pool_px1,
    input  logic signed [wordlength-1:0] pool_data,
    output logic                         out_valid,
    output logic signed [wordlength-1:0] out_data,
    output logic                         out_last,
    input  logic                         out_ready
);

    localparam int ColW = idx_width(dataColNum);
    localparam int RowW = idx_width(dataRowNum);
    localparam logic [ColW-1:0] LastCol = ColW'(dataColNum - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(dataRowNum - 1);
    localparam logic [ColW-1:0] ColOne  = ColW'(1);
    localparam logic [RowW-1:0] RowOne  = RowW'(1);

    state_t                         r_state;
    logic [ColW-1:0]                r_col;
    logic [RowW-1:0]                r_row;
    logic signed [wordlength-1:0]   r_hold_even;
    logic signed [wordlength-1:0]   r_hold_odd;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic signed [wordlength-1:0]   r_out_data;
    logic                           r_out_last;

    logic                           w_accept;
    logic                           w_stall;
    logic                           w_buf_we;
    logic                           w_last_col;
    logic                           w_last_row;
    logic [ColW-1:0]                w_col_prev;
    logic [wordlength-1:0]          w_rd0;
    logic [wordlength-1:0]          w_rd1;

    assign w_accept   = in_valid && r_in_ready;
    assign w_stall    = r_out_valid && !out_ready;
    assign w_buf_we   = (r_state == StFill) && w_accept;
    assign w_last_col = (r_col == LastCol);
    assign w_last_row = (r_row == LastRow);
    assign w_col_prev = r_col - ColOne;

    pool_line_buf #(
        .Depth (dataColNum),
        .Width (wordlength),
        .AddrW (ColW)
    ) u_line_buf (
        .clk      (clk),
        .i_we     (w_buf_we),
        .i_waddr  (r_col),
        .i_wdata  (in_pixel),
        .i_raddr0 (w_col_prev),
        .o_rdata0 (w_rd0),
        .i_raddr1 (r_col),
        .o_rdata1 (w_rd1)
    );

    // Issue is combinational so a stall can react to out_ready in the same cycle.
    always_comb begin
        pool_valid = 1'b0;
        pool_px0   = '0;
        pool_px1   = '0;
        case (r_state)
            StIssue0: begin
                if (!w_stall) begin
                    pool_valid = 1'b1;
                    pool_px0   = w_rd0;
                    pool_px1   = r_hold_even;
                end
            end
            StIssue1: begin
                pool_valid = 1'b1;
                pool_px0   = w_rd1;
                pool_px1   = r_hold_odd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            r_state     <= StFill;
            r_col       <= '0;
            r_row       <= '0;
            r_hold_even <= '0;
            r_hold_odd  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                StFill: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col   <= '0;
                            r_row   <= r_row + RowOne;
                            r_state <= StOddAcc;
                        end else begin
                            r_col <= r_col + ColOne;
                        end
                    end
                end
                StOddAcc: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (!r_col[0]) begin
                            r_hold_even <= in_pixel;
                            r_col       <= r_col + ColOne;
                        end else begin
                            // Column stays on the odd pixel until the window is captured.
                            r_hold_odd <= in_pixel;
                            r_in_ready <= 1'b0;
                            r_state    <= StIssue0;
                        end
                    end
                end
                StIssue0: begin
                    if (!w_stall) begin
                        r_state <= StIssue1;
                    end
                end
                StIssue1: begin
                    r_state <= StCapture;
                end
                StCapture: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= pool_data;
                    r_out_last  <= w_last_col && w_last_row;
                    r_in_ready  <= 1'b1;
                    if (w_last_col) begin
                        r_col   <= '0;
                        r_row   <= w_last_row ? '0 : r_row + RowOne;
                        r_state <= StFill;
                    end else begin
                        r_col   <= r_col + ColOne;
                        r_state <= StOddAcc;
                    end
                end
                default: begin
                    r_state    <= StFill;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_pool2d_sched.sv
// Scoreboard bench for pool2d_sched on a 4x4 frame with a behavioural max-pool unit attached.
module tb_pool2d_sched;

    localparam int Cols = 4;
    localparam int Rows = 4;
    localparam int W    = 16;
    localparam int NPx  = Cols * Rows;

    typedef logic signed [W-1:0] px_t;
    typedef px_t frame_t [NPx];
    typedef struct {
        px_t  data;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic irst = 1'b1;
    logic in_valid = 1'b0;
    px_t  in_pixel = '0;
    logic in_ready;
    logic pool_valid;
    px_t  pool_px0;
    px_t  pool_px1;
    px_t  pool_data;
    logic out_valid;
    px_t  out_data;
    logic out_last;
    logic out_ready = 1'b1;

    always #5 clk = ~clk;

    pool2d_sched #(
        .dataColNum (Cols),
        .dataRowNum (Rows),
        .wordlength (W)
    ) dut (
        .clk        (clk),
        .irst       (irst),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .pool_valid (pool_valid),
        .pool_px0   (pool_px0),
        .pool_px1   (pool_px1),
        .pool_data  (pool_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    // Max-pool unit: restarts its running max on the first valid cycle after an idle one.
    px_t  pm_max;
    logic pm_prev;

    function automatic px_t smax(input px_t a, input px_t b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or posedge irst) begin
        if (irst) begin
            pm_max  <= '0;
            pm_prev <= 1'b0;
        end else begin
            if (pool_valid) begin
                pm_max <= pm_prev ? smax(pm_max, smax(pool_px0, pool_px1))
                                  : smax(pool_px0, pool_px1);
            end
            pm_prev <= pool_valid;
        end
    end
    assign pool_data = pm_max;

    int   errors = 0;
    int   checks = 0;
    int   n_rx   = 0;
    int   run    = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input px_t d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard on the output port plus pool_valid shape checks.
    always @(negedge clk) begin
        if (irst) begin
            run = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_rx++;
                    end
                end
            end
            if (out_valid && !out_ready && run == 0) begin
                chk("stall_no_issue", pool_valid, 0);
            end
            if (pool_valid) begin
                run++;
                chk("in_ready_issue", in_ready, 0);
            end else begin
                chk("px0_idle", pool_px0, 0);
                chk("px1_idle", pool_px1, 0);
                if (run != 0) begin
                    chk("pool_valid_run", run, 2);
                    chk("in_ready_capture", in_ready, 0);
                end
                run = 0;
            end
        end
    end

    task automatic send_px(input px_t v);
        int n = 0;
        in_valid = 1'b1;
        in_pixel = v;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_pixel = '0;
    endtask

    task automatic send_frame(input frame_t f, input int gap);
        for (int i = 0; i < NPx; i++) begin
            send_px(f[i]);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic push_inc_results(input px_t base);
        push_exp(base + 16'sd5, 1'b0);
        push_exp(base + 16'sd7, 1'b0);
        push_exp(base + 16'sd13, 1'b0);
        push_exp(base + 16'sd15, 1'b1);
    endtask

    frame_t f_inc;
    frame_t f_neg;
    frame_t f_new;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NPx; i++) begin
            f_inc[i] = px_t'(i + 1);
            f_new[i] = px_t'(i + 100);
            f_neg[i] = -16'sd5;
        end
        f_neg[0]  = -16'sd1;
        f_neg[7]  = -16'sd1;
        f_neg[9]  = -16'sd1;
        f_neg[14] = -16'sd1;

        // Reset values while irst is held.
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pool_valid", pool_valid, 0);
        chk("rst_px0", pool_px0, 0);
        chk("rst_px1", pool_px1, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        irst = 1'b0;
        @(posedge clk);
        #1;
        chk("fill_in_ready", in_ready, 1);

        // Ascending frame, sink always ready.
        push_inc_results(16'sd1);
        send_frame(f_inc, 0);
        wait_drain();
        chk("t1_count", n_rx, 4);

        // Negative pixels, one -1 per window in varying positions.
        for (int k = 0; k < 4; k++) push_exp(-16'sd1, k == 3);
        send_frame(f_neg, 0);
        wait_drain();
        chk("t2_count", n_rx, 8);

        // Back-pressure for 20 cycles right after the first result appears.
        push_inc_results(16'sd1);
        fork
            send_frame(f_inc, 0);
            begin
                int n = 0;
                while (!out_valid && n < 500) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t3_count", n_rx, 12);

        // in_valid toggled every other cycle.
        push_inc_results(16'sd1);
        send_frame(f_inc, 1);
        wait_drain();
        chk("t4_count", n_rx, 16);

        // Reset at row 1 col 1, then a fresh frame.
        for (int i = 0; i < Cols + 1; i++) send_px(f_inc[i]);
        chk("t5_pre_pending", exp_q.size(), 0);
        irst = 1'b1;
        #2;
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_pool_valid", pool_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        irst = 1'b0;
        push_inc_results(16'sd100);
        send_frame(f_new, 0);
        wait_drain();
        chk("t5_count", n_rx, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
